// File: rtl/dct_pkg.sv
// ---------------------------------------------------------------------------
// dct_pkg
// Shared constants and types for the DCT coefficient accumulator.
//   BLOCK_PIX : pixels per 8x8 block
//   IDX_W     : width of the in-block pixel counter
//   FRAC_BITS : fractional bits of the Q10 cosine term
//   state_t   : accumulator FSM states
// ---------------------------------------------------------------------------
package dct_pkg;

    localparam int BLOCK_PIX = 64;
    localparam int IDX_W     = $clog2(BLOCK_PIX);
    localparam int FRAC_BITS = 10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_DRAIN,
        S_HOLD
    } state_t;

endpackage

// File: rtl/dct_coeff_accum_if.sv
// ---------------------------------------------------------------------------
// dct_coeff_accum_if
// Bundles the pixel stream, the cosine LUT lookup and the coefficient stream
// of one dct_coeff_accum instance.
//   pix/pix_valid/pix_ready      : pixel stream into the accumulator
//   n1/n2/cos_term               : LUT index out, cosine term back (same cycle)
//   coef/coef_sat/coef_valid/
//   coef_ready                   : coefficient stream out of the accumulator
//   state                        : FSM state, for observation only
// Modports: slave = the accumulator, master = its environment.
// ---------------------------------------------------------------------------
interface dct_coeff_accum_if #(
    parameter int PIX_W  = 8,
    parameter int COS_W  = 32,
    parameter int COEF_W = 16
);
    import dct_pkg::*;

    logic        [PIX_W-1:0]  pix;
    logic                     pix_valid;
    logic                     pix_ready;
    logic        [2:0]        n1;
    logic        [2:0]        n2;
    logic signed [COS_W-1:0]  cos_term;
    logic signed [COEF_W-1:0] coef;
    logic                     coef_sat;
    logic                     coef_valid;
    logic                     coef_ready;
    state_t                   state;

    modport slave (
        input  pix, pix_valid, cos_term, coef_ready,
        output pix_ready, n1, n2, coef, coef_sat, coef_valid, state
    );

    modport master (
        output pix, pix_valid, cos_term, coef_ready,
        input  pix_ready, n1, n2, coef, coef_sat, coef_valid, state
    );

endinterface

// File: rtl/dct_coeff_accum_sat.sv
// ---------------------------------------------------------------------------
// dct_coeff_sat
// Combinational output stage: removes the Q fraction from the accumulator
// with an arithmetic (flooring) shift and clips to the signed coefficient
// range.
//   acc  : signed accumulator value
//   coef : clipped coefficient
//   sat  : high when clipping occurred
// ---------------------------------------------------------------------------
module dct_coeff_sat #(
    parameter int ACC_W     = 32,
    parameter int COEF_W    = 16,
    parameter int FRAC_BITS = 10
) (
    input  logic signed [ACC_W-1:0]  acc,
    output logic signed [COEF_W-1:0] coef,
    output logic                     sat
);

    localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'((64'sd1 <<< (COEF_W - 1)) - 64'sd1);
    // Two's complement: -MAX-1 == ~MAX.
    localparam logic signed [ACC_W-1:0] MIN_V = ~MAX_V;

    logic signed [ACC_W-1:0] shifted;

    always_comb begin
        shifted = acc >>> FRAC_BITS;
        coef    = shifted[COEF_W-1:0];
        sat     = 1'b0;
        if (shifted > MAX_V) begin
            coef = MAX_V[COEF_W-1:0];
            sat  = 1'b1;
        end else if (shifted < MIN_V) begin
            coef = MIN_V[COEF_W-1:0];
            sat  = 1'b1;
        end
    end

endmodule

// File: rtl/dct_coeff_accum.sv
// ---------------------------------------------------------------------------
// dct_coeff_accum
// Streams one 8x8 pixel block in raster order, drives the cosine LUT index
// (n1,n2) from the accepted-pixel count, multiplies each pixel by the
// returned Q10 cosine term and accumulates all 64 products. Two edges after
// the last pixel a saturated coefficient is presented on the output stream.
//
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   clr   : synchronous abort; drops the partial block, returns to idle
//   bus   : dct_coeff_accum_if.slave (pixel stream, LUT lookup,
//           coefficient stream, FSM state)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. The producer keeps data stable while valid is high and ready is
// low; coef/coef_sat/coef_valid are held until coef_ready is seen.
//
// Build option: DCT_LEVEL_SHIFT_EN defined -> pix is unsigned and is level
// shifted by -2^(PIX_W-1); undefined -> pix is signed two's complement.
// ---------------------------------------------------------------------------
module dct_coeff_accum #(
    parameter int PIX_W     = 8,
    parameter int COS_W     = 32,
    parameter int ACC_W     = 32,
    parameter int COEF_W    = 16,
    parameter int FRAC_BITS = dct_pkg::FRAC_BITS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    dct_coeff_accum_if.slave      bus
);
    import dct_pkg::*;

    state_t                   state_q;
    state_t                   state_d;
    logic                     load_coef;

    logic        [IDX_W-1:0]  idx_q;
    logic signed [ACC_W-1:0]  prod_q;
    logic                     prod_vld_q;
    logic                     first_q;
    logic signed [ACC_W-1:0]  acc_q;

    logic signed [COEF_W-1:0] coef_q;
    logic                     coef_sat_q;
    logic                     coef_valid_q;

    logic                     pix_ready;
    logic                     accept;
    logic                     handshake;

    logic signed [PIX_W:0]    p;
    logic signed [ACC_W-1:0]  p_x;
    logic signed [ACC_W-1:0]  c_x;
    logic signed [ACC_W-1:0]  prod_next;

    logic signed [COEF_W-1:0] sat_coef;
    logic                     sat_flag;

    // Pixel operand, widened by one bit so both encodings fit signed.
`ifdef DCT_LEVEL_SHIFT_EN
    assign p = $signed({1'b0, bus.pix}) - $signed((PIX_W + 1)'(1 << (PIX_W - 1)));
`else
    assign p = $signed({bus.pix[PIX_W-1], bus.pix});
`endif

    // Only the low ACC_W bits of the product are kept, so the multiply is
    // done directly at ACC_W on sign-extended operands.
    assign p_x       = ACC_W'(p);
    assign c_x       = ACC_W'(bus.cos_term);
    assign prod_next = p_x * c_x;

    assign pix_ready = (state_q == S_IDLE) || (state_q == S_ACCUM);
    // A pixel presented together with clr is never taken.
    assign accept    = bus.pix_valid && pix_ready && !clr;
    assign handshake = coef_valid_q && bus.coef_ready;

    always_comb begin
        state_d   = state_q;
        load_coef = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (accept) state_d = S_ACCUM;
            end
            S_ACCUM: begin
                if (accept && (idx_q == IDX_W'(BLOCK_PIX - 1))) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                // First drain cycle: the last product is still in stage 1.
                // Once it has been folded into acc, capture the result.
                if (!prod_vld_q) begin
                    state_d   = S_HOLD;
                    load_coef = 1'b1;
                end
            end
            S_HOLD: begin
                if (handshake) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (clr) begin
            state_d   = S_IDLE;
            load_coef = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q        <= '0;
            prod_q       <= '0;
            prod_vld_q   <= 1'b0;
            first_q      <= 1'b0;
            acc_q        <= '0;
            coef_q       <= '0;
            coef_sat_q   <= 1'b0;
            coef_valid_q <= 1'b0;
        end else if (clr) begin
            idx_q        <= '0;
            prod_vld_q   <= 1'b0;
            first_q      <= 1'b0;
            coef_valid_q <= 1'b0;
        end else begin
            // Stage 1: multiply on accept; idx wraps naturally after 63.
            if (accept) begin
                idx_q      <= idx_q + 1'b1;
                prod_q     <= prod_next;
                first_q    <= (idx_q == '0);
                prod_vld_q <= 1'b1;
            end else begin
                prod_vld_q <= 1'b0;
            end

            // Stage 2: only a valid product touches acc, so input gaps are harmless.
            if (prod_vld_q) begin
                acc_q <= (first_q ? '0 : acc_q) + prod_q;
            end

            if (load_coef) begin
                coef_q       <= sat_coef;
                coef_sat_q   <= sat_flag;
                coef_valid_q <= 1'b1;
            end else if (handshake) begin
                coef_valid_q <= 1'b0;
            end
        end
    end

    dct_coeff_sat #(
        .ACC_W     (ACC_W),
        .COEF_W    (COEF_W),
        .FRAC_BITS (FRAC_BITS)
    ) u_sat (
        .acc  (acc_q),
        .coef (sat_coef),
        .sat  (sat_flag)
    );

    assign bus.pix_ready  = pix_ready;
    assign bus.n1         = idx_q[5:3];
    assign bus.n2         = idx_q[2:0];
    assign bus.coef       = coef_q;
    assign bus.coef_sat   = coef_sat_q;
    assign bus.coef_valid = coef_valid_q;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_dct_coeff_accum.sv
// ---------------------------------------------------------------------------
// tb_dct_coeff_accum
// Self-checking bench for dct_coeff_accum. The cosine LUT is an 8x8 table
// indexed by the DUT's n1/n2; expected coefficients come from a plain
// arithmetic dot product of the block with the table.
// ---------------------------------------------------------------------------
module tb_dct_coeff_accum;

    localparam int PIX_W  = 8;
    localparam int COS_W  = 32;
    localparam int ACC_W  = 32;
    localparam int COEF_W = 16;
    localparam int FRAC   = dct_pkg::FRAC_BITS;

`ifdef DCT_LEVEL_SHIFT_EN
    localparam logic [PIX_W-1:0] PMAX = 8'hFF;
`else
    localparam logic [PIX_W-1:0] PMAX = 8'h7F;
`endif

    logic clk;
    logic rst_n;
    logic clr;

    dct_coeff_accum_if bus ();

    dct_coeff_accum dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- LUT model ----------------
    logic        [PIX_W-1:0] blk [64];
    logic signed [COS_W-1:0] lut [64];

    assign bus.cos_term = lut[{bus.n1, bus.n2}];

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [COEF_W:0] exp_q [$];

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic longint pval(input logic [PIX_W-1:0] v);
`ifdef DCT_LEVEL_SHIFT_EN
        return longint'(v) - (longint'(1) << (PIX_W - 1));
`else
        return longint'($signed(v));
`endif
    endfunction

    // {sat, coef} for the current blk/lut contents.
    function automatic logic [COEF_W:0] model();
        longint s = 0;
        longint a;
        longint q;
        longint den = longint'(1) << FRAC;
        longint maxv = (longint'(1) << (COEF_W - 1)) - 1;
        longint minv = -(longint'(1) << (COEF_W - 1));
        logic sat = 1'b0;
        for (int i = 0; i < 64; i++) s += pval(blk[i]) * longint'(lut[i]);
        a = longint'($signed(s[ACC_W-1:0]));
        q = a / den;
        if (a < 0 && (a % den) != 0) q = q - 1;
        if (q > maxv) begin q = maxv; sat = 1'b1; end
        if (q < minv) begin q = minv; sat = 1'b1; end
        return {sat, COEF_W'(q)};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_pixels(input int first, input int last, input int gap_max);
        for (int i = first; i <= last; i++) begin
            int gap = $urandom_range(0, gap_max);
            repeat (gap) begin
                bus.pix_valid = 1'b0;
                bus.pix = PIX_W'($urandom);
                @(posedge clk); #1;
            end
            bus.pix_valid = 1'b1;
            bus.pix = blk[i];
            begin
                int w = 0;
                while (!bus.pix_ready && w < 50) begin
                    @(posedge clk); #1;
                    w++;
                end
                if (w >= 50) chk("accept_timeout", 0, 1);
            end
            chk("n1n2_idx", longint'({bus.n1, bus.n2}), i);
            @(posedge clk); #1;
        end
        bus.pix_valid = 1'b0;
    endtask

    task automatic run_block(input int gap_max, input int hold, output logic signed [COEF_W-1:0] got);
        logic [COEF_W:0] e;
        exp_q.push_back(model());
        drive_pixels(0, 63, gap_max);
        // Pixels offered during drain/hold must be refused.
        bus.pix_valid = 1'b1;
        bus.pix = PIX_W'($urandom);
        chk("valid_e0", bus.coef_valid, 0);
        chk("drain_ready", bus.pix_ready, 0);
        @(posedge clk); #1;
        chk("valid_e1", bus.coef_valid, 0);
        @(posedge clk); #1;
        chk("valid_e2", bus.coef_valid, 1);
        e = exp_q.pop_front();
        got = bus.coef;
        chk("coef", longint'($signed(bus.coef)), longint'($signed(e[COEF_W-1:0])));
        chk("coef_sat", bus.coef_sat, e[COEF_W]);
        repeat (hold) begin
            chk("hold_ready", bus.pix_ready, 0);
            @(posedge clk); #1;
            chk("hold_valid", bus.coef_valid, 1);
            chk("hold_coef", longint'($signed(bus.coef)), longint'($signed(e[COEF_W-1:0])));
            chk("hold_sat", bus.coef_sat, e[COEF_W]);
        end
        bus.coef_ready = 1'b1;
        bus.pix_valid  = 1'b0;
        @(posedge clk); #1;
        bus.coef_ready = 1'b0;
        chk("valid_after_hs", bus.coef_valid, 0);
        chk("ready_after_hs", bus.pix_ready, 1);
        chk("idx_after_hs", longint'({bus.n1, bus.n2}), 0);
        chk("state_after_hs", longint'(bus.state), longint'(dct_pkg::S_IDLE));
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_coef"},  longint'($signed(bus.coef)), 0);
        chk({tag, "_sat"},   bus.coef_sat, 0);
        chk({tag, "_valid"}, bus.coef_valid, 0);
        chk({tag, "_ready"}, bus.pix_ready, 1);
        chk({tag, "_idx"},   longint'({bus.n1, bus.n2}), 0);
        chk({tag, "_state"}, longint'(bus.state), longint'(dct_pkg::S_IDLE));
    endtask

    task automatic fill_block(input logic [PIX_W-1:0] v, input logic signed [COS_W-1:0] c);
        for (int i = 0; i < 64; i++) begin
            blk[i] = v;
            lut[i] = c;
        end
    endtask

    // ---------------- stimulus ----------------
    logic signed [COEF_W-1:0] got;
    logic signed [COEF_W-1:0] ref_t1;

    initial begin
        rst_n          = 1'b1;
        clr            = 1'b0;
        bus.pix        = '0;
        bus.pix_valid  = 1'b0;
        bus.coef_ready = 1'b0;
        fill_block(PMAX, 32'sh400);
        #3 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Uniform block, unity cosine.
        fill_block(PMAX, 32'sh400);
        run_block(0, 0, got);
        ref_t1 = got;
`ifdef DCT_LEVEL_SHIFT_EN
        chk("t1_coef_8128", longint'(got), 8128);
`endif
        // Same block with input gaps gives the same coefficient.
        run_block(3, 1, got);
        chk("gaps_unchanged", longint'(got), longint'(ref_t1));

        // Single off-mid pixel against a negative cosine entry.
        fill_block(8'd128, 32'sh400);
        blk[9] = 8'd228;
        lut[9] = -32'sh36;
        run_block(1, 0, got);
`ifdef DCT_LEVEL_SHIFT_EN
        chk("t2_coef_m6", longint'(got), -6);
`endif

        // Positive and negative saturation.
        fill_block(PMAX, 32'sh7FFF);
        run_block(0, 0, got);
        chk("t3_coef_max", longint'(got), 32767);
        fill_block(PMAX, -32'sh7FFF);
        run_block(0, 0, got);
        chk("t3_coef_min", longint'(got), -32768);

        // Backpressure: coef_ready held low for 10 cycles.
        fill_block(PMAX, 32'sh400);
        run_block(0, 10, got);

        // Abort at pixel 30, then a full clean block.
        for (int i = 0; i < 64; i++) begin
            blk[i] = PIX_W'($urandom);
            lut[i] = 32'sh400;
        end
        drive_pixels(0, 29, 1);
        bus.pix_valid = 1'b1;
        bus.pix = blk[30];
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        bus.pix_valid = 1'b0;
        chk("clr_idx", longint'({bus.n1, bus.n2}), 0);
        chk("clr_valid", bus.coef_valid, 0);
        chk("clr_ready", bus.pix_ready, 1);
        chk("clr_state", longint'(bus.state), longint'(dct_pkg::S_IDLE));
        fill_block(PMAX, 32'sh400);
        run_block(1, 1, got);
        chk("clr_no_residue", longint'(got), longint'(ref_t1));

        // Async reset mid-block, then a full clean block.
        for (int i = 0; i < 64; i++) blk[i] = PIX_W'($urandom);
        drive_pixels(0, 39, 1);
        rst_n = 1'b0;
        #1;
        check_reset_values("midrst");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        fill_block(PMAX, 32'sh400);
        run_block(0, 0, got);
        chk("rst_no_residue", longint'(got), longint'(ref_t1));

        // Random blocks and tables.
        for (int b = 0; b < 6; b++) begin
            for (int i = 0; i < 64; i++) begin
                blk[i] = PIX_W'($urandom);
                lut[i] = COS_W'($urandom_range(0, 3000));
                lut[i] = lut[i] - 32'sd1500;
            end
            run_block($urandom_range(0, 3), $urandom_range(0, 4), got);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
